// File: rtl/subbytes_seq_if.sv
// Streaming handshake bundle for subbytes_seq: one 128-bit AES state in,
// one transformed state out, each with valid/ready.
interface subbytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/subbytes_seq.sv
// Serial AES SubBytes over one shared pipelined sbox (16 bytes per state).
// Optional macro SUBBYTES_SHIFTROWS_EN folds ShiftRows into the result write address.
module subbytes_sbox #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the sbox requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h01;
        t = a;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [7:0] pipe [LAT];

    // Sbox data pipeline; deliberately not reset, the issuer tracks validity.
    always_ff @(posedge clk) begin
        pipe[0] <= affine(gf_inv(addr));
        for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign data = pipe[LAT-1];
endmodule

module subbytes_seq #(
    parameter int SBOX_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    subbytes_seq_if.slave        bus,
    output logic                 busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic         issued_all;
    logic [127:0] work;
    logic [127:0] result;
    logic         tag_v   [SBOX_LAT];
    logic [3:0]   tag_idx [SBOX_LAT];

    logic [7:0]   sbox_addr;
    logic [7:0]   sbox_data;
    logic         issue;
    logic         wr_en;
    logic [3:0]   wr_pos;
    logic         last_wr;

    function automatic logic [3:0] dest_pos(input logic [3:0] k);
`ifdef SUBBYTES_SHIFTROWS_EN
        logic [1:0] col;
        col = k[3:2] - k[1:0];
        return {col, k[1:0]};
`else
        return k;
`endif
    endfunction

    assign sbox_addr = work[{cnt, 3'b000} +: 8];
    assign issue     = (state == ST_RUN) && !issued_all;
    assign wr_en     = tag_v[SBOX_LAT-1];
    assign wr_pos    = dest_pos(tag_idx[SBOX_LAT-1]);
    assign last_wr   = wr_en && (tag_idx[SBOX_LAT-1] == 4'd15);

    subbytes_sbox #(.LAT(SBOX_LAT)) u_sbox (
        .clk  (clk),
        .addr (sbox_addr),
        .data (sbox_data)
    );

    // Control FSM, issue counter, valid-tag pipeline beside the sbox, and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            issued_all <= 1'b0;
            work       <= 128'd0;
            result     <= 128'd0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_idx[i] <= 4'd0;
            end
        end else begin
            tag_v[0]   <= issue;
            tag_idx[0] <= cnt;
            for (int i = 1; i < SBOX_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end

            if (wr_en) begin
                result[{wr_pos, 3'b000} +: 8] <= sbox_data;
            end else begin
                result <= result;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        work       <= bus.in_data;
                        cnt        <= 4'd0;
                        issued_all <= 1'b0;
                        state      <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (cnt == 4'd15) issued_all <= 1'b1;
                        else              cnt        <= cnt + 4'd1;
                    end else begin
                        cnt <= cnt;
                    end
                    if (last_wr) state <= ST_DONE;
                    else         state <= ST_RUN;
                end
                ST_DONE: begin
                    if (bus.out_ready) state <= ST_IDLE;
                    else               state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = result;
    assign busy          = (state != ST_IDLE);
endmodule

// File: tb/tb_subbytes_seq.sv
// Randomised self-checking bench for subbytes_seq against a brute-force GF(2^8) sbox model.
module tb_subbytes_seq;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   total = 0;
    int   bad = 0;
    int   edge_no = 0;
    logic [7:0] sbox_tab [256];

    subbytes_seq_if bus();

    subbytes_seq #(.SBOX_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_mul(int a, int b);
        int p = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ (32'h11b << (i - 8));
        return p & 255;
    endfunction

    task automatic build_sbox;
        for (int x = 0; x < 256; x++) begin
            int inv = 0;
            logic [7:0] b, s;
            if (x != 0) for (int y = 1; y < 256; y++) if (ref_mul(x, y) == 1) inv = y;
            b = 8'(inv);
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_state(logic [127:0] s);
        logic [127:0] o = '0;
        for (int k = 0; k < 16; k++) begin
            int r = k % 4;
            int c = k / 4;
            int d;
`ifdef SUBBYTES_SHIFTROWS_EN
            d = r + 4 * ((c - r + 4) % 4);
`else
            d = k;
`endif
            o[d*8 +: 8] = sbox_tab[s[k*8 +: 8]];
        end
        return o;
    endfunction

    function automatic logic [127:0] fill(logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic tick;
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    // Accepts d (block must be idle) and waits for out_valid; lat = edges after accept, -1 on timeout.
    task automatic run_one(input logic [127:0] d, output int lat, output logic [127:0] got);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        got = bus.out_data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        total++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b100 || bus.out_data !== 128'd0) begin
            bad++;
            $display("FAIL reset: rdy/vld/busy=%b data=%h required 100 / 0",
                     {bus.in_ready, bus.out_valid, busy}, bus.out_data);
        end
    endtask

    task automatic test_zero;
        int lat = -1;
        int flag_bad = 0;
        logic [127:0] got;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = '0;
        tick();
        bus.in_valid = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (busy !== 1'b1 || bus.in_ready !== 1'b0) flag_bad++;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        got = bus.out_data;
        total++;
        if (lat !== 16 + LAT) begin bad++; $display("FAIL zero_latency: got %0d required %0d", lat, 16 + LAT); end
        total++;
        if (got !== fill(8'h63)) begin bad++; $display("FAIL zero_data: got %h required %h", got, fill(8'h63)); end
        total++;
        if (flag_bad !== 0) begin bad++; $display("FAIL zero_busy: %0d cycles with busy!=1 or in_ready!=0", flag_bad); end
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_one_pulse: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_vector;
        logic [127:0] d, got, req;
        logic [7:0] e [16];
        int lat;
`ifdef SUBBYTES_SHIFTROWS_EN
        e = '{8'h63, 8'h6B, 8'h67, 8'h76, 8'hF2, 8'h01, 8'hAB, 8'h7B,
              8'h30, 8'hD7, 8'h77, 8'hC5, 8'hFE, 8'h7C, 8'h6F, 8'h2B};
`else
        e = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
              8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};
`endif
        for (int k = 0; k < 16; k++) begin
            d[k*8 +: 8]   = 8'(k);
            req[k*8 +: 8] = e[k];
        end
        bus.out_ready = 1'b1;
        run_one(d, lat, got);
        total++;
        if (got !== req) begin bad++; $display("FAIL vector: got %h required %h", got, req); end
        tick();
    endtask

    task automatic test_random;
        logic [127:0] d, got, req;
        int lat;
        for (int t = 0; t < 8; t++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            req = ref_state(d);
            bus.out_ready = 1'b0;
            run_one(d, lat, got);
            total++;
            if (lat !== 16 + LAT || got !== req) begin
                bad++;
                $display("FAIL random_%0d: lat=%0d data=%h required lat=%0d data=%h", t, lat, got, 16 + LAT, req);
            end
            repeat ($urandom_range(0, 3)) tick();
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] d, got, req;
        int lat;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        req = ref_state(d);
        bus.out_ready = 1'b0;
        run_one(d, lat, got);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = c[0];
            bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== req) begin
                bad++;
                $display("FAIL backpressure_%0d: vld=%b rdy=%b data=%h required 1 0 %h",
                         c, bus.out_valid, bus.in_ready, bus.out_data, req);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release: vld=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_mid_reset;
        logic [127:0] got;
        int lat;
        int pulses = 0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        bus.in_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b100 || bus.out_data !== 128'd0) begin
            bad++;
            $display("FAIL mid_reset: rdy/vld/busy=%b data=%h required 100 / 0",
                     {bus.in_ready, bus.out_valid, busy}, bus.out_data);
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        total++;
        if (pulses !== 0 || bus.out_data !== 128'd0) begin
            bad++;
            $display("FAIL mid_reset_quiet: pulses=%0d data=%h required 0 / 0", pulses, bus.out_data);
        end
        run_one(fill(8'hFF), lat, got);
        total++;
        if (lat !== 16 + LAT || got !== fill(8'h16)) begin
            bad++;
            $display("FAIL mid_reset_ff: lat=%0d data=%h required %0d %h", lat, got, 16 + LAT, fill(8'h16));
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int acc_edge [2];
        int naccept = 0;
        int pulses = 0;
        logic [127:0] outs [2];
        logic acc;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = fill(8'h53);
        for (int c = 0; c < 80; c++) begin
            acc = bus.in_ready && bus.in_valid;
            tick();
            if (acc) begin
                if (naccept < 2) acc_edge[naccept] = edge_no;
                naccept++;
                if (naccept == 1) bus.in_data = fill(8'h01);
            end
            if (bus.out_valid) begin
                if (pulses < 2) outs[pulses] = bus.out_data;
                pulses++;
                if (pulses == 2) bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        total++;
        if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d required 2", pulses); end
        if (pulses >= 2 && naccept >= 2) begin
            total++;
            if (acc_edge[1] - acc_edge[0] !== 18 + LAT) begin
                bad++;
                $display("FAIL b2b_spacing: got %0d required %0d", acc_edge[1] - acc_edge[0], 18 + LAT);
            end
            total++;
            if (outs[0] !== fill(8'hED) || outs[1] !== fill(8'h7C) || outs[1] !== ref_state(fill(8'h01))) begin
                bad++;
                $display("FAIL b2b_data: got %h %h required %h %h", outs[0], outs[1], fill(8'hED), fill(8'h7C));
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        test_reset();
        test_zero();
        test_vector();
        test_random();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/subbytes_seq.md
SUBBYTES_SEQ -- requirements
Module: subbytes_seq

Interface
REQ-001 The block SHALL have parameter SBOX_LAT, default 1, giving the sbox instance latency in clock edges from address to captured data; legal values are 1..2.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port in_valid, input, 1 bit: in_data is offered.
REQ-005 Port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-006 Port in_data, input, 128 bits: the AES state; byte i = in_data[8i+7:8i], with row = i mod 4 and col = i div 4.
REQ-007 Port out_valid, output, 1 bit: out_data is valid.
REQ-008 Port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-009 Port out_data, output, 128 bits: the transformed state, using the same byte layout as in_data.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 The block SHALL contain exactly one sbox instance (the pipelined computational sbox, clock on clk) and SHALL stream the 16 bytes through it serially.
REQ-012 The state machine SHALL have states IDLE, RUN and DONE.
- in_ready = 1 only in IDLE.
- out_valid = 1 only in DONE.
REQ-013 Accept: when in_valid & in_ready on an edge, the block SHALL register in_data into the work register, clear the 4-bit issue counter, and enter RUN.
REQ-014 In RUN, the sbox address SHALL equal work byte[cnt]; cnt SHALL increment each cycle and saturate at 15 once byte 15 has been issued.
REQ-015 The sbox result for byte k SHALL be written to result byte k on edge E0+k+1+SBOX_LAT, where E0 is the accepting edge.
REQ-016 On the edge that writes byte 15 (E0+16+SBOX_LAT), the block SHALL enter DONE; with SBOX_LAT=1, out_valid therefore rises 17 edges after acceptance.
REQ-017 In DONE, out_data SHALL hold stable until out_valid & out_ready, then the block SHALL return to IDLE on that edge.
- in_ready is first high in the following cycle.
- A new accept is not possible in the same cycle as the output handshake.
REQ-018 in_valid SHALL be ignored outside IDLE; in_data changes during RUN or DONE SHALL NOT affect the result.
REQ-019 If out_ready is already high when DONE is entered, out_valid SHALL be high for exactly one cycle.
REQ-020 Sustained throughput SHALL be one state per 18+SBOX_LAT cycles when out_ready is held high.

Reset
REQ-021 When rst_n=0 on a rising edge, the block SHALL enter IDLE, clear cnt, and clear the work and result registers to zero.
- After reset: out_valid=0, out_data=0, in_ready=1, busy=0.
REQ-022 A reset during RUN or DONE SHALL discard the operation in progress; no out_valid pulse SHALL follow it.
REQ-023 The sbox internal pipeline register is not reset; sbox values in flight at reset SHALL NOT be written to the result register.

Configuration
REQ-024 With macro SUBBYTES_SHIFTROWS_EN defined, the result write address SHALL be permuted to apply AES ShiftRows.
- Sbox result of input byte at (row r, col c) is written to output position (r, (c-r) mod 4).
- Latency and handshake are unchanged.
REQ-025 Without SUBBYTES_SHIFTROWS_EN, result byte k SHALL be written to output position k (SubBytes only).

Verification
REQ-026 Reset then all-zero in_data, out_ready=1 → out_valid rises exactly 17 edges after acceptance with out_data = 0x63 in every byte; busy=1 throughout; in_ready=0 throughout.
REQ-027 in_data bytes 0..15 = 0x00..0x0F, no macro → out_data bytes 0..15 = 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76.
- With SUBBYTES_SHIFTROWS_EN, the same input → bytes = 63 6B 67 76 F2 01 AB 7B 30 D7 77 C5 FE 7C 6F 2B.
REQ-028 Backpressure: out_ready=0 for 5 cycles in DONE → out_valid and out_data stable, in_ready=0, in_valid pulses ignored; then out_ready=1 → return to IDLE on that edge, in_ready=1 next cycle.
REQ-029 Reset mid-operation: rst_n=0 for one edge when cnt=8 → next cycle in_ready=1, out_valid=0, busy=0, out_data=0.
- A following all-0xFF input → all bytes 0x16 after 17 edges.
REQ-030 Back-to-back: in_valid=1 continuously, out_ready=1, two states (0x53 everywhere, then 0x01 everywhere).
- Outputs all-0xED, then all-0x7C.
- Accept edges are 19 cycles apart.
- Exactly two out_valid pulses.
